// File: rtl/led_matrix_pkg.sv
// Shared constants, scan state encoding and pixel indexing for the LED matrix scanner.
package led_matrix_pkg;
  localparam bit ACT_HIGH = 1'b1;
  localparam bit ACT_LOW  = 1'b0;

  typedef enum logic {BLANK = 1'b0, SCAN = 1'b1} scan_state_t;

  // Row-major bitmap: bit r*cols+c is row r, column c.
  function automatic int pix_idx(input int r, input int c, input int cols);
    return r * cols + c;
  endfunction
endpackage

// File: rtl/led_matrix_scanner_if.sv
// Frame load handshake between a frame source (master) and the scanner (slave).
interface led_matrix_scanner_if #(
  parameter int FRAME_W = 64
);
  logic [FRAME_W-1:0] frame_in;
  logic               load_valid;
  logic               load_ready;

  modport master (output frame_in, output load_valid, input load_ready);
  modport slave  (input frame_in, input load_valid, output load_ready);
endinterface

// File: rtl/scan_timebase.sv
// Prescaler, PWM slot counter and column counter; all held at zero while not running.
module scan_timebase #(
  parameter int COLS  = 8,
  parameter int DIV_W = 16,
  parameter int PWM_W = 4,
  parameter int CW    = $clog2(COLS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic [DIV_W-1:0] scan_div,
  output logic [PWM_W-1:0] slot_cnt,
  output logic [CW-1:0]    col,
  output logic             frame_end
);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  logic [DIV_W-1:0] div_reg;
  logic [PWM_W-1:0] slot_reg;
  logic [CW-1:0]    col_reg;
  logic             slot_tick;
  logic             col_tick;

  // >= so a live decrease of scan_div below div_reg still ends the slot.
  assign slot_tick = run && (div_reg >= scan_div);
  assign col_tick  = slot_tick && (slot_reg == {PWM_W{1'b1}});
  assign frame_end = col_tick && (col_reg == COL_LAST);

  assign slot_cnt = slot_reg;
  assign col      = col_reg;

  always_ff @(posedge clk) begin
    if (!rst || !run) begin
      div_reg  <= '0;
      slot_reg <= '0;
      col_reg  <= '0;
    end else if (slot_tick) begin
      div_reg  <= '0;
      slot_reg <= slot_reg + 1'b1;
      if (col_tick) begin
        col_reg <= frame_end ? '0 : col_reg + 1'b1;
      end
    end else begin
      div_reg <= div_reg + 1'b1;
    end
  end
endmodule

// File: rtl/led_matrix_scanner.sv
// Double-buffered, PWM-dimmed column-scan LED matrix driver with tear-free frame swaps.
module led_matrix_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROWS    = 8,
  parameter int COLS    = 8,
  parameter int DIV_W   = 16,
  parameter int PWM_W   = 4,
  parameter bit ROW_ACT = ACT_HIGH,
  parameter bit COL_ACT = ACT_LOW
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  led_matrix_scanner_if.slave  load,
  input  logic [DIV_W-1:0]     scan_div,
  input  logic [PWM_W-1:0]     brightness,
  output logic [ROWS-1:0]      rows,
  output logic [COLS-1:0]      colms,
  output logic                 frame_done
);
  localparam int CW = $clog2(COLS);
  localparam int FW = ROWS * COLS;
  localparam int IW = $clog2(FW);

  scan_state_t      state_reg, state_next;
  logic             run, lit, frame_end, swap, accept;
  logic             pending_reg, frame_done_reg;
  logic [PWM_W-1:0] slot_cnt;
  logic [CW-1:0]    col;
  logic [FW-1:0]    shadow_reg, active_reg;
  logic [ROWS-1:0]  pix, rows_reg, rows_next;
  logic [COLS-1:0]  colms_reg, colms_next;

  scan_timebase #(
    .COLS (COLS),
    .DIV_W(DIV_W),
    .PWM_W(PWM_W),
    .CW   (CW)
  ) u_timebase (
    .clk      (clk),
    .rst      (rst),
    .run      (run),
    .scan_div (scan_div),
    .slot_cnt (slot_cnt),
    .col      (col),
    .frame_end(frame_end)
  );

  for (genvar gi = 0; gi < ROWS; gi++) begin : g_pix
    assign pix[gi] = active_reg[IW'(pix_idx(gi, int'(col), COLS))];
  end

  always_ff @(posedge clk) begin
    if (!rst) state_reg <= BLANK;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      BLANK:   if (en)  state_next = SCAN;
      SCAN:    if (!en) state_next = BLANK;
      default: state_next = BLANK;
    endcase
    // Dropping en blanks on the very next edge, before the state register follows.
    run        = (state_reg == SCAN) && en;
    lit        = run && (slot_cnt < brightness);
    rows_next  = {ROWS{~ROW_ACT}};
    colms_next = {COLS{~COL_ACT}};
    if (lit) begin
      rows_next  = ROW_ACT ? pix : ~pix;
      colms_next[col] = COL_ACT;
    end
  end

  // Shadow is only writable while nothing is pending, so accept and swap never coincide.
  assign accept          = load.load_valid && !pending_reg;
  assign swap            = pending_reg && (frame_end || (state_reg == BLANK));
  assign load.load_ready = !pending_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      pending_reg <= 1'b0;
      shadow_reg  <= '0;
      active_reg  <= '0;
    end else begin
      if (swap) begin
        active_reg  <= shadow_reg;
        pending_reg <= 1'b0;
      end
      if (accept) begin
        shadow_reg  <= load.frame_in;
        pending_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rows_reg       <= {ROWS{~ROW_ACT}};
      colms_reg      <= {COLS{~COL_ACT}};
      frame_done_reg <= 1'b0;
    end else begin
      rows_reg       <= rows_next;
      colms_reg      <= colms_next;
      frame_done_reg <= frame_end;
    end
  end

  assign rows       = rows_reg;
  assign colms      = colms_reg;
  assign frame_done = frame_done_reg;
endmodule

// File: tb/tb_led_matrix_scanner.sv
// Self-checking bench: table vectors, hand sequences and a randomized run against a behavioural model.
module tb_led_matrix_scanner;
  localparam int C  = 8;
  localparam int R  = 8;
  localparam int NS = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0;
  logic [15:0] scan_div = '0;
  logic [3:0]  brightness = '0;
  logic [7:0]  rows, colms;
  logic        frame_done;

  logic        b_en = 1'b0;
  logic [3:0]  b_div = '0;
  logic [1:0]  b_br = '0;
  logic [4:0]  b_rows;
  logic [6:0]  b_colms;
  logic        b_fd;

  int checks = 0;
  int failures = 0;

  led_matrix_scanner_if #(.FRAME_W(64)) a_if ();
  led_matrix_scanner_if #(.FRAME_W(35)) b_if ();

  led_matrix_scanner dut_a (
    .clk(clk), .rst(rst), .en(en), .load(a_if), .scan_div(scan_div),
    .brightness(brightness), .rows(rows), .colms(colms), .frame_done(frame_done)
  );

  led_matrix_scanner #(
    .ROWS(5), .COLS(7), .DIV_W(4), .PWM_W(2), .ROW_ACT(1'b0), .COL_ACT(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst), .en(b_en), .load(b_if), .scan_div(b_div),
    .brightness(b_br), .rows(b_rows), .colms(b_colms), .frame_done(b_fd)
  );

  always #5 clk = ~clk;

  // Reference model: scan position counted in whole PWM slots across the frame.
  int          m_on, m_pos, m_el;
  bit          m_pending;
  logic [63:0] m_active, m_shadow;
  logic [7:0]  e_rows, e_colms;
  logic        e_fd, e_ready;

  task automatic model_update();
    int slot, col;
    bit run, tick, fend, lit;
    logic [63:0] sh;
    if (!rst) begin
      m_on = 0; m_pos = 0; m_el = 0; m_pending = 0;
      m_active = '0; m_shadow = '0;
      e_rows = 8'h00; e_colms = 8'hFF; e_fd = 1'b0; e_ready = 1'b1;
      return;
    end
    run  = (m_on != 0) && en;
    slot = m_pos % NS;
    col  = m_pos / NS;
    tick = run && (m_el >= int'(scan_div));
    fend = tick && (m_pos == C * NS - 1);
    lit  = run && (slot < int'(brightness));
    e_rows = 8'h00;
    e_colms = 8'hFF;
    if (lit) begin
      for (int r = 0; r < R; r++) begin
        sh = m_active >> (r * C + col);
        e_rows[r] = sh[0];
      end
      e_colms = ~(8'h01 << col);
    end
    e_fd = fend;
    if (m_pending && (fend || m_on == 0)) begin
      m_active = m_shadow;
      m_pending = 0;
    end else if (a_if.load_valid && !m_pending) begin
      m_shadow = a_if.frame_in;
      m_pending = 1;
    end
    if (!run) begin
      m_pos = 0; m_el = 0;
    end else if (tick) begin
      m_el = 0;
      m_pos = (m_pos + 1) % (C * NS);
    end else begin
      m_el++;
    end
    m_on = en ? 1 : 0;
    e_ready = !m_pending;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("model", 64'({rows, colms, frame_done, a_if.load_ready}),
          64'({e_rows, e_colms, e_fd, e_ready}));
  endtask

  task automatic wait_colms(input logic [7:0] target, input int limit, output bit ok);
    ok = 0;
    for (int k = 0; k < limit && !ok; k++) begin
      step();
      if (colms == target) ok = 1;
    end
  endtask

  task automatic load_a(input logic [63:0] f);
    a_if.frame_in = f;
    a_if.load_valid = 1'b1;
    step();
    a_if.load_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] sdiv;
    logic [3:0]  br;
    logic [63:0] frame;
    int          cycles;
    int          exp_col0_lit;
    int          exp_total_lit;
    int          exp_fd;
    logic [7:0]  exp_rows_col0;
  } vec_t;

  task automatic run_vector(input vec_t vv, input int idx);
    int col0_lit, total_lit, fd_cnt, bad;
    rst = 1'b0; en = 1'b0; step();
    rst = 1'b1;
    load_a(vv.frame);
    step();
    scan_div = vv.sdiv; brightness = vv.br; en = 1'b1;
    step();
    col0_lit = 0; total_lit = 0; fd_cnt = 0; bad = 0;
    for (int k = 1; k <= vv.cycles; k++) begin
      step();
      if (colms != 8'hFF) total_lit++;
      if (colms == 8'hFE) begin
        col0_lit++;
        if (rows != vv.exp_rows_col0) bad++;
      end
      if (frame_done) fd_cnt++;
    end
    check($sformatf("vec%0d_col0_lit", idx), 64'(col0_lit), 64'(vv.exp_col0_lit));
    check($sformatf("vec%0d_total_lit", idx), 64'(total_lit), 64'(vv.exp_total_lit));
    check($sformatf("vec%0d_frame_done", idx), 64'(fd_cnt), 64'(vv.exp_fd));
    check($sformatf("vec%0d_rows_col0_bad", idx), 64'(bad), 64'h0);
    en = 1'b0;
    step();
  endtask

  initial begin
    vec_t vecs[4];
    bit ok, seen_fd;
    logic prev_ready;
    int bad;
    logic [34:0] frame_b;
    logic [34:0] sh_b;
    logic [4:0] er;
    logic [6:0] ec;

    vecs[0] = '{16'd0, 4'd15, 64'h0000_0000_0000_00FF, 256, 30, 240, 2, 8'h01};
    vecs[1] = '{16'd3, 4'd4,  64'h8000_0000_0000_0001, 512, 16, 128, 1, 8'h01};
    vecs[2] = '{16'd1, 4'd0,  64'hFFFF_FFFF_FFFF_FFFF, 256, 0,  0,   1, 8'hFF};
    vecs[3] = '{16'd0, 4'd8,  64'h0101_0101_0101_0101, 128, 8,  64,  1, 8'hFF};

    a_if.frame_in = '0; a_if.load_valid = 1'b0;
    b_if.frame_in = '0; b_if.load_valid = 1'b0;

    // Reset held two clocks with en high.
    rst = 1'b0; en = 1'b1;
    step(); step();
    check("reset_rows", 64'(rows), 64'h00);
    check("reset_colms", 64'(colms), 64'hFF);
    check("reset_ready", 64'(a_if.load_ready), 64'h1);
    check("reset_done", 64'(frame_done), 64'h0);
    rst = 1'b1; en = 1'b0;
    step();

    for (int v = 0; v < 4; v++) run_vector(vecs[v], v);

    // Tear-free swap: frame B loaded at column 3 must not show until the next frame.
    rst = 1'b0; step(); rst = 1'b1;
    load_a(64'h0000_0000_0000_00FF);
    step();
    scan_div = 16'd0; brightness = 4'd15; en = 1'b1;
    wait_colms(8'hF7, 300, ok);
    check("tf_reach_col3", 64'(ok), 64'h1);
    load_a(64'hFF00_0000_0000_0000);
    a_if.frame_in = 64'hDEAD_BEEF_0123_4567;
    check("tf_ready_low", 64'(a_if.load_ready), 64'h0);
    bad = 0; seen_fd = 0; prev_ready = a_if.load_ready;
    for (int k = 0; k < 300 && !seen_fd; k++) begin
      step();
      if (frame_done) begin
        seen_fd = 1;
        check("tf_ready_with_done", 64'(a_if.load_ready), 64'h1);
        check("tf_ready_before_done", 64'(prev_ready), 64'h0);
      end else begin
        prev_ready = a_if.load_ready;
        if (colms != 8'hFF && rows != 8'h01) bad++;
      end
    end
    check("tf_seen_done", 64'(seen_fd), 64'h1);
    check("tf_old_frame_kept", 64'(bad), 64'h0);
    step();
    check("tf_new_col0", 64'({colms, rows}), 64'h0000_0000_0000_FE80);

    // Disable with a pending frame at column 5.
    wait_colms(8'hDF, 300, ok);
    check("dis_reach_col5", 64'(ok), 64'h1);
    load_a(64'h0000_0000_0000_FF00);
    check("dis_ready_low", 64'(a_if.load_ready), 64'h0);
    en = 1'b0;
    step();
    check("dis_blank_out", 64'({rows, colms}), 64'h0000_0000_0000_00FF);
    check("dis_ready_still_low", 64'(a_if.load_ready), 64'h0);
    step();
    check("dis_swap_ready", 64'(a_if.load_ready), 64'h1);
    en = 1'b1;
    step();
    check("dis_restart_blank", 64'(colms), 64'hFF);
    step();
    check("dis_restart_col0", 64'({colms, rows}), 64'h0000_0000_0000_FE02);

    // Randomized run; the model check inside step() does the comparing.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 599) != 0);
      en = ($urandom_range(0, 99) < 97);
      a_if.load_valid = ($urandom_range(0, 9) == 0);
      a_if.frame_in = {$urandom(), $urandom()};
      if ($urandom_range(0, 49) == 0) scan_div = 16'($urandom_range(0, 3));
      if ($urandom_range(0, 49) == 0) brightness = 4'($urandom_range(0, 15));
      step();
    end
    rst = 1'b1; en = 1'b0; a_if.load_valid = 1'b0;

    // 5x7 instance with inverted polarities.
    rst = 1'b0; step(); step();
    check("b_reset_rows", 64'(b_rows), 64'h1F);
    check("b_reset_colms", 64'(b_colms), 64'h00);
    check("b_reset_ready", 64'(b_if.load_ready), 64'h1);
    check("b_reset_done", 64'(b_fd), 64'h0);
    rst = 1'b1;
    frame_b = '0;
    for (int r = 0; r < 5; r++) frame_b[r * 7 + r] = 1'b1;
    frame_b[34] = 1'b1;
    b_if.frame_in = frame_b; b_if.load_valid = 1'b1;
    step();
    b_if.load_valid = 1'b0;
    step();
    b_div = 4'd0; b_br = 2'd3; b_en = 1'b1;
    step();
    for (int k = 1; k <= 60; k++) begin
      int p, col, slot;
      bit lit;
      step();
      p = k - 1;
      col = (p / 4) % 7;
      slot = p % 4;
      lit = (slot < 3);
      ec = lit ? (7'h01 << col) : 7'h00;
      for (int r = 0; r < 5; r++) begin
        sh_b = frame_b >> (r * 7 + col);
        er[r] = lit ? ~sh_b[0] : 1'b1;
      end
      check($sformatf("b_scan_k%0d", k), 64'({b_rows, b_colms, b_fd}),
            64'({er, ec, (k % 28) == 0}));
    end
    b_en = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
